// File: rtl/node_serial_mac.sv
// node_serial_mac: float32 neuron node that time-shares one multiplier and one adder over a
// valid/ready stream of activation/weight pairs. Define NODE_RELU_EN to clamp negative results to 0.
module node_serial_mac #(
   parameter int unsigned N_INPUTS = 187,
   parameter logic [31:0] BIAS     = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [31:0] in_weight,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
);
   // state | meaning
   // ACC   | accepting pairs, products accumulate one per cycle
   // DRAIN | input stalled, last in-flight product is added
   // OUT   | result presented until the consumer takes it
   localparam logic [1:0] S_ACC   = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_OUT   = 2'd2;
   localparam int CW = $clog2(N_INPUTS + 1);

   // Round-to-nearest-even; subnormals flush to zero, NaN collapses to the canonical quiet NaN.
   function automatic logic [31:0] float_mult(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [47:0] p;
      logic [23:0] m;
      logic [9:0]  e;
      logic        g, st;
      s = a[31] ^ b[31];
      if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0))
         return 32'h7FC00000;
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
         return (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
      if (p[47]) begin
         m  = {1'b0, p[46:24]};
         g  = p[23];
         st = |p[22:0];
         e  = e + 10'd1;
      end else begin
         m  = {1'b0, p[45:23]};
         g  = p[22];
         st = |p[21:0];
      end
      if (g && (st || m[0])) m = m + 24'd1;
      if (m[23]) begin
         m = 24'd0;
         e = e + 10'd1;
      end
      if (e[9] || e == 10'd0) return {s, 31'h0};
      if (e >= 10'd255) return {s, 8'hFF, 23'h0};
      return {s, e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] float_adder(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [26:0] mx, my, sh;
      logic [27:0] sum;
      logic [7:0]  d;
      logic [9:0]  e;
      logic [23:0] m;
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
         if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a != b) return 32'h7FC00000;
         return (a[30:23] == 8'hFF) ? a : b;
      end
      if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? {a[31] & b[31], 31'h0} : b;
      if (b[30:23] == 8'h00) return a;
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      d  = x[30:23] - y[30:23];
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      // bits shifted out of the smaller operand fold into a sticky LSB
      if (d >= 8'd27) sh = 27'd1;
      else begin
         sh = my >> d;
         if ((sh << d) != my) sh[0] = 1'b1;
      end
      e = {2'b0, x[30:23]};
      if (x[31] == y[31]) begin
         sum = {1'b0, mx} + {1'b0, sh};
         if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 10'd1;
         end
      end else begin
         sum = {1'b0, mx} - {1'b0, sh};
         if (sum == 28'd0) return 32'h0;
         for (int i = 0; i < 26; i++) begin
            if (!sum[26]) begin
               sum = sum << 1;
               e   = e - 10'd1;
            end
         end
      end
      m = {1'b0, sum[25:3]};
      if (sum[2] && (sum[1] || sum[0] || sum[3])) m = m + 24'd1;
      if (m[23]) begin
         m = 24'd0;
         e = e + 10'd1;
      end
      if (e[9] || e == 10'd0) return {x[31], 31'h0};
      if (e >= 10'd255) return {x[31], 8'hFF, 23'h0};
      return {x[31], e[7:0], m[22:0]};
   endfunction

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   acc_q, acc_d;
   logic [31:0]   prod_q, prod_d;
   logic          prod_vld_q, prod_vld_d;
   logic          in_hs, out_hs;
   logic [31:0]   prod_w, sum_w;

   assign in_ready  = (state_q == S_ACC);
   assign out_valid = (state_q == S_OUT);
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign prod_w    = float_mult(in_data, in_weight);
   assign sum_w     = float_adder(acc_q, prod_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      prod_d     = prod_q;
      prod_vld_d = in_hs;
      if (in_hs) begin
         prod_d = prod_w;
         cnt_d  = cnt_q + CW'(1);
      end
      if (prod_vld_q) acc_d = sum_w;
      case (state_q)
         S_ACC:   if (in_hs && cnt_q == CW'(N_INPUTS - 1)) state_d = S_DRAIN;
         S_DRAIN: state_d = S_OUT;
         S_OUT: begin
            if (out_hs) begin
               state_d = S_ACC;
               acc_d   = BIAS;
               cnt_d   = '0;
            end
         end
         default: state_d = S_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_ACC;
         cnt_q      <= '0;
         acc_q      <= BIAS;
         prod_q     <= 32'h0;
         prod_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         prod_q     <= prod_d;
         prod_vld_q <= prod_vld_d;
      end
   end

`ifdef NODE_RELU_EN
   assign out_data = (state_q == S_OUT && !acc_q[31]) ? acc_q : 32'h0;
`else
   assign out_data = (state_q == S_OUT) ? acc_q : 32'h0;
`endif

endmodule
